// File: rtl/instr_pipe_regs.sv
// Instruction register chain IF -> ID -> EX -> MEM -> WB feeding the hazard unit.
// Applies HDU stall (hold ID/PC, bubble EX) and branch flush, and counts stalls/retires.
module instr_pipe_regs #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       if_instr,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic             stall,
  input  logic             flush,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic [PC_W-1:0]  pc,
  output logic [7:0]       id_instr,
  output logic [7:0]       ex_instr,
  output logic [7:0]       mem_instr,
  output logic [7:0]       wb_instr,
  output logic             wb_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [7:0] BUBBLE = 8'h00;

  logic id_valid;
  logic ex_valid;
  logic mem_valid;

  // Fetch handshake: if_instr transfers into ID on an edge where if_valid and
  // if_ready are both high and flush is low. A flush raises if_ready so the
  // fetch side never waits on a redirect, but that cycle's fetch is dropped.
  assign if_ready = ~stall | flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc         <= '0;
      id_instr   <= BUBBLE;
      id_valid   <= 1'b0;
      ex_instr   <= BUBBLE;
      ex_valid   <= 1'b0;
      mem_instr  <= BUBBLE;
      mem_valid  <= 1'b0;
      wb_instr   <= BUBBLE;
      wb_valid   <= 1'b0;
      stall_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      // MEM and WB advance in every mode; only ID/EX/PC depend on flush/stall.
      wb_instr  <= mem_instr;
      wb_valid  <= mem_valid;
      mem_instr <= ex_instr;
      mem_valid <= ex_valid;

      if (mem_valid && (retire_cnt != '1)) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end

      if (flush) begin
        id_instr <= BUBBLE;
        id_valid <= 1'b0;
        ex_instr <= BUBBLE;
        ex_valid <= 1'b0;
        pc       <= redirect_pc;
      end else if (stall) begin
        ex_instr <= BUBBLE;
        ex_valid <= 1'b0;
        if (stall_cnt != '1) begin
          stall_cnt <= stall_cnt + CNT_W'(1);
        end
      end else begin
        ex_instr <= id_instr;
        ex_valid <= id_valid;
        id_instr <= if_valid ? if_instr : BUBBLE;
        id_valid <= if_valid;
        pc       <= pc + PC_W'(if_valid);
      end
    end
  end

endmodule

// File: tb/tb_instr_pipe_regs.sv
// Directed bench for instr_pipe_regs: reset, straight line, stall, flush,
// flush+stall, mid-stream reset, and PC wrap / counter saturation on a narrow instance.
module tb_instr_pipe_regs;

  logic       clk;
  logic       resetn;
  logic [7:0] if_instr;
  logic       if_valid;
  logic       if_ready;
  logic       stall;
  logic       flush;
  logic [7:0] redirect_pc;
  logic [7:0] pc;
  logic [7:0] id_instr;
  logic [7:0] ex_instr;
  logic [7:0] mem_instr;
  logic [7:0] wb_instr;
  logic       wb_valid;
  logic [15:0] stall_cnt;
  logic [15:0] retire_cnt;

  logic       s_if_valid;
  logic [7:0] s_if_instr;
  logic       s_if_ready;
  logic       s_stall;
  logic       s_flush;
  logic [3:0] s_redirect_pc;
  logic [3:0] s_pc;
  logic [7:0] s_id_instr;
  logic [7:0] s_ex_instr;
  logic [7:0] s_mem_instr;
  logic [7:0] s_wb_instr;
  logic       s_wb_valid;
  logic [1:0] s_stall_cnt;
  logic [1:0] s_retire_cnt;

  int n_checks;
  int n_errors;
  logic [7:0] exp_q[$];

  instr_pipe_regs #(.PC_W(8), .CNT_W(16)) u_dut (
    .clk(clk), .resetn(resetn), .if_instr(if_instr), .if_valid(if_valid),
    .if_ready(if_ready), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
    .pc(pc), .id_instr(id_instr), .ex_instr(ex_instr), .mem_instr(mem_instr),
    .wb_instr(wb_instr), .wb_valid(wb_valid), .stall_cnt(stall_cnt),
    .retire_cnt(retire_cnt)
  );

  instr_pipe_regs #(.PC_W(4), .CNT_W(2)) u_small (
    .clk(clk), .resetn(resetn), .if_instr(s_if_instr), .if_valid(s_if_valid),
    .if_ready(s_if_ready), .stall(s_stall), .flush(s_flush), .redirect_pc(s_redirect_pc),
    .pc(s_pc), .id_instr(s_id_instr), .ex_instr(s_ex_instr), .mem_instr(s_mem_instr),
    .wb_instr(s_wb_instr), .wb_valid(s_wb_valid), .stall_cnt(s_stall_cnt),
    .retire_cnt(s_retire_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [7:0] instr);
    if_valid = 1'b1;
    if_instr = instr;
    step();
    if_valid = 1'b0;
  endtask

  task automatic check_stages(input string tag, input logic [7:0] id_e, input logic [7:0] ex_e,
                              input logic [7:0] mem_e, input logic [7:0] wb_e);
    check_eq({tag, "_id"}, id_instr, id_e);
    check_eq({tag, "_ex"}, ex_instr, ex_e);
    check_eq({tag, "_mem"}, mem_instr, mem_e);
    check_eq({tag, "_wb"}, wb_instr, wb_e);
  endtask

  // scoreboard: every real instruction reaching WB must match the expected order
  always @(posedge clk) begin
    #2;
    if (resetn && wb_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_retire", {24'h0, wb_instr}, 32'hFFFF_FFFF);
      end else begin
        check_eq("sb_retire", {24'h0, wb_instr}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    if_instr = 8'h00; if_valid = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = 8'h00;
    s_if_instr = 8'h00; s_if_valid = 1'b0; s_stall = 1'b0; s_flush = 1'b0; s_redirect_pc = 4'h0;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    #1;
    check_stages("rst", 8'h00, 8'h00, 8'h00, 8'h00);
    check_eq("rst_pc", pc, 0);
    check_eq("rst_wb_valid", wb_valid, 0);
    check_eq("rst_stall_cnt", stall_cnt, 0);
    check_eq("rst_retire_cnt", retire_cnt, 0);
    step();
    step();
    resetn = 1'b1;

    // straight line
    exp_q = '{8'h11, 8'h26, 8'h3C, 8'h00, 8'hA7, 8'h11, 8'h62};
    fetch(8'h11);
    check_eq("sl1_id", id_instr, 8'h11);
    check_eq("sl1_pc", pc, 1);
    fetch(8'h26);
    check_eq("sl2_ex", ex_instr, 8'h11);
    fetch(8'h3C);
    check_eq("sl3_mem", mem_instr, 8'h11);
    fetch(8'h00);
    check_stages("sl4", 8'h00, 8'h3C, 8'h26, 8'h11);
    check_eq("sl4_wb_valid", wb_valid, 1);
    check_eq("sl4_pc", pc, 4);
    check_eq("sl4_retire", retire_cnt, 1);

    // stall with ADD R0,R1 in ID
    fetch(8'hA7);
    fetch(8'h11);
    check_stages("pre_stall", 8'h11, 8'hA7, 8'h00, 8'h3C);
    check_eq("pre_stall_pc", pc, 6);
    stall = 1'b1; if_valid = 1'b1; if_instr = 8'h55;
    #1;
    check_eq("stall_if_ready", if_ready, 0);
    step();
    check_stages("stall1", 8'h11, 8'h00, 8'hA7, 8'h00);
    check_eq("stall1_pc", pc, 6);
    check_eq("stall1_cnt", stall_cnt, 1);
    step();
    check_stages("stall2", 8'h11, 8'h00, 8'h00, 8'hA7);
    check_eq("stall2_pc", pc, 6);
    check_eq("stall2_cnt", stall_cnt, 2);
    check_eq("stall2_retire", retire_cnt, 5);
    stall = 1'b0; if_valid = 1'b0;
    step();
    check_stages("unstall", 8'h00, 8'h11, 8'h00, 8'h00);
    check_eq("unstall_wb_valid", wb_valid, 0);

    // flush
    fetch(8'h62);
    fetch(8'h73);
    check_stages("pre_flush", 8'h73, 8'h62, 8'h00, 8'h11);
    check_eq("pre_flush_pc", pc, 8);
    flush = 1'b1; redirect_pc = 8'h40; if_valid = 1'b1; if_instr = 8'h99;
    #1;
    check_eq("flush_if_ready", if_ready, 1);
    step();
    flush = 1'b0; if_valid = 1'b0;
    check_stages("flush", 8'h00, 8'h00, 8'h62, 8'h00);
    check_eq("flush_pc", pc, 8'h40);
    step();
    check_stages("post_flush", 8'h00, 8'h00, 8'h00, 8'h62);
    check_eq("post_flush_retire", retire_cnt, 7);

    // flush and stall together
    fetch(8'h84);
    check_eq("fs_pre_id", id_instr, 8'h84);
    check_eq("fs_pre_pc", pc, 8'h41);
    flush = 1'b1; stall = 1'b1; redirect_pc = 8'h20; if_valid = 1'b1; if_instr = 8'h5A;
    #1;
    check_eq("fs_if_ready", if_ready, 1);
    step();
    flush = 1'b0; stall = 1'b0; if_valid = 1'b0;
    check_eq("fs_id", id_instr, 8'h00);
    check_eq("fs_pc", pc, 8'h20);
    check_eq("fs_stall_cnt", stall_cnt, 2);

    // reset mid-stream, between edges
    fetch(8'hC3);
    fetch(8'hD4);
    #2 resetn = 1'b0;
    #1;
    check_stages("mid_rst", 8'h00, 8'h00, 8'h00, 8'h00);
    check_eq("mid_rst_pc", pc, 0);
    check_eq("mid_rst_stall_cnt", stall_cnt, 0);
    check_eq("mid_rst_retire_cnt", retire_cnt, 0);
    check_eq("mid_rst_wb_valid", wb_valid, 0);
    step();
    resetn = 1'b1;
    exp_q.push_back(8'h11);
    fetch(8'h11);
    check_eq("restart_id", id_instr, 8'h11);
    check_eq("restart_pc", pc, 1);

    // narrow instance: PC wrap and counter saturation
    for (int i = 0; i < 17; i++) begin
      s_if_valid = 1'b1;
      s_if_instr = 8'(8'h10 + i);
      step();
    end
    s_if_valid = 1'b0;
    check_eq("wrap_pc", s_pc, 1);
    check_eq("sat_retire", s_retire_cnt, 3);
    s_stall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_eq("sat_stall3", s_stall_cnt, 3);
    step();
    step();
    s_stall = 1'b0;
    check_eq("sat_stall5", s_stall_cnt, 3);
    check_eq("sat_stall5_pc", s_pc, 1);

    step();
    check_eq("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
